pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit that drives the `write_enable` and `flush` inputs of the PC and of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects three conditions and emits the matching stall and bubble pattern:
- load-use hazards in ID;
- taken branches/jumps resolved in EX;
- multi-cycle multiply/divide operations occupying EX.

It updates state on the same falling clock edge on which the pipeline registers capture, and keeps a stall-cycle performance counter.

## Interface
- `MUL_CYCLES`, default 4: total EX occupancy of a multiply, in cycles (legal range 2..63).
- `DIV_CYCLES`, default 32: total EX occupancy of a divide, in cycles (legal range 2..63).
- `clk` in 1: clock; all state updates on negedge.
- `Rst` in 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: ID instruction reads that source.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_branch_taken` in 1: EX redirects the PC this cycle.
- `ex_md_start` in 1: EX holds a multiply/divide that is starting.
- `ex_md_is_div` in 1: 1 = divide, 0 = multiply; sampled with `ex_md_start`.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we` out 1 each: write enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: flush requests. Each is only meaningful with the matching `_we` = 1.
- `md_busy` out 1: FSM is in MD_BUSY.
- `md_done` out 1: final EX cycle of a multiply/divide.
- `stall_cnt` out 32: count of cycles with `pc_we` = 0; wraps at 2^32.

## Operation
- **State:**
  - FSM with two states, RUN and MD_BUSY.
  - 6-bit down-counter `cnt`.
  - 32-bit `stall_cnt`.
- **Reset values:** state RUN, `cnt` = 0, `stall_cnt` = 0. While `Rst` = 1, all outputs take their RUN/no-hazard values.
- **Output logic:** all outputs are combinational from the current state, `cnt` and the inputs.
- **Default (RUN, no event):** all `_we` = 1, all `_flush` = 0, `md_busy` = `md_done` = 0.
- **Load-use condition:**
  - Requires `ex_mem_read` = 1 and `ex_rd` != 0.
  - Also requires `(id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd)`.
  - Response: `pc_we` = 0, `ifid_we` = 0, `idex_we` = 1 with `idex_flush` = 1 (bubble); the rest stay at default.
- **Branch taken (RUN):**
  - `pc_we` = 1 (PC loads the target).
  - `ifid_we` = 1 with `ifid_flush` = 1, and `idex_we` = 1 with `idex_flush` = 1.
  - EX/MEM and MEM/WB stay at default.
- **Multiply/divide start (RUN, `ex_md_start` = 1):**
  - `pc_we` = `ifid_we` = `idex_we` = 0.
  - `exmem_we` = 1 with `exmem_flush` = 1; `memwb_we` = 1.
  - At the next negedge: state ← MD_BUSY, `cnt` ← N−2, where N = `DIV_CYCLES` if `ex_md_is_div` = 1, else `MUL_CYCLES`.
- **MD_BUSY, `cnt` != 0:** same stall pattern as the start cycle; `md_busy` = 1; `cnt` decrements at negedge.
- **MD_BUSY, `cnt` == 0 (release cycle):**
  - All `_we` = 1, all `_flush` = 0, `md_busy` = 1, `md_done` = 1.
  - State ← RUN at negedge.
- **Priority in RUN:** `ex_branch_taken` > `ex_md_start` > load-use.
  - Branch wins over load-use because the ID instruction is wrong-path.
  - `ex_md_start` together with `ex_branch_taken` is illegal; branch behaviour applies and no MD_BUSY is entered.
- **Inputs ignored in MD_BUSY:** `ex_md_start`, `ex_branch_taken` and load-use. Load-use is re-evaluated in RUN after release.
- **`stall_cnt`:** increments at every negedge where `pc_we` = 0 and `Rst` = 0.

## Timing
- Stall and flush outputs respond in the same cycle as the triggering input, and must be stable before the negedge on which the pipeline registers capture.
- Multiply/divide EX occupancy is exactly N cycles: 1 start cycle, N−2 busy-stall cycles, 1 release cycle. That gives N−1 stalled cycles per op.
  - MUL: 3 stalls, release in cycle 4.
  - DIV: 31 stalls, release in cycle 32.
- A load-use hazard costs exactly 1 stall cycle. On the following cycle, ID/EX holds a bubble and the hazard condition is clear.
- A taken branch costs 2 flushed slots and no stall.
- `Rst` asserted mid-operation (for example in MD_BUSY with `cnt` = 10): state becomes RUN immediately and asynchronously, `cnt` = 0, `stall_cnt` = 0, outputs return to default in the same cycle.
- `cnt` is only loaded on RUN→MD_BUSY; it never underflows.

## Test plan
- Reset, then idle 5 cycles → all `_we` = 1, all `_flush` = 0, `stall_cnt` = 0.
- Load-use: `ex_mem_read` = 1, `ex_rd` = 5, `id_rs` = 5, `id_uses_rs` = 1 for one cycle → `pc_we` = `ifid_we` = 0, `idex_flush` = 1 for exactly 1 cycle, `stall_cnt` = 1. Repeat with `ex_rd` = 0 → no stall.
- Branch and load-use together → `ifid_flush` = `idex_flush` = 1, `pc_we` = 1, `stall_cnt` unchanged.
- Multiply (`ex_md_start` = 1, `ex_md_is_div` = 0) → `pc_we` = 0 for 3 cycles, `md_done` = 1 in cycle 4, `stall_cnt` += 3. A branch pulse during busy is ignored.
- Divide → 31 stall cycles, `md_done` in cycle 32, then RUN. Back-to-back `ex_md_start` on the cycle after release → new 31-cycle busy period.
- `Rst` asserted at busy cycle 10 of a divide → immediate RUN and default outputs, `stall_cnt` = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush controller (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, ex_md_start, ex_md_is_div,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, ex_md_start, ex_md_is_div,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, taken branch and multi-cycle
// multiply/divide occupancy of EX, plus a stalled-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               Rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   stall_cnt;
  logic          load_use;
  logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic          md_busy, md_done;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

  // Next state and same-cycle stall/flush pattern; reset forces the idle pattern.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (!Rst) begin
      case (state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.ex_md_start) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            state_nxt   = MD_BUSY;
            cnt_nxt     = hz.ex_md_is_div ? DIV_LOAD : MUL_LOAD;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          md_busy = 1'b1;
          if (cnt != '0) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            cnt_nxt     = CW'(cnt - 1'b1);
          end else begin
            md_done   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State updates on the falling edge, when the pipeline registers capture.
  always_ff @(negedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_we) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.ifid_we     = ifid_we;
  assign hz.idex_we     = idex_we;
  assign hz.exmem_we    = exmem_we;
  assign hz.memwb_we    = memwb_we;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.md_busy     = md_busy;
  assign hz.md_done     = md_done;
  assign hz.stall_cnt   = stall_cnt;

endmodule
